// File: rtl/v_hier_pkg.sv
// Shared constants and the lane width/sign rule for the v_hier leaf pipeline.
// Lanes are handled at up to EXT_W bits wide.
package v_hier_pkg;

  localparam int DEF_WIDTH_OUT = 8;
  localparam int DEF_CNT_W     = 16;
  localparam int EXT_W         = 64;

  // Bits at or above width_in are padded with the lane MSB when
  // signed_mode=1, or with 0 otherwise. The caller takes the low bits it
  // needs, so a narrower output is simply a truncation.
  function automatic logic [EXT_W-1:0] ext_lane(input logic [EXT_W-1:0] val,
                                                input int width_in,
                                                input logic signed_mode);
    logic [EXT_W-1:0] r;
    logic [5:0]       msb_idx;
    logic             pad;
    msb_idx = 6'(width_in - 1);
    pad     = signed_mode & val[msb_idx];
    r       = '0;
    for (int i = 0; i < EXT_W; i++) begin
      r[i] = (i < width_in) ? val[i] : pad;
    end
    return r;
  endfunction

endpackage

// File: rtl/v_hier_subsub_stage.sv
// One elastic valid/data register slice.
// The slice accepts from upstream whenever it is empty or downstream is taking its beat.
module v_hier_subsub_stage
  import v_hier_pkg::*;
#(
  parameter int DATA_W = DEF_WIDTH_OUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  input  logic              dn_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              rdy
);

  assign rdy = !valid | dn_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (rdy) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/v_hier_subsub_pipe.sv
// Multi-lane elastic pipeline leaf: lanes are extended or truncated at the input and carried through DEPTH slices.
// The top level also reports stage occupancy and a saturating count of delivered beats.
module v_hier_subsub_pipe
  import v_hier_pkg::*;
#(
  parameter int IGNORED   = 0,
  parameter int WIDTH_IN  = 1,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH_IN-1:0]  a,
  input  logic                          signed_mode,
  output logic                          q_valid,
  input  logic                          q_ready,
  output logic [CHANNELS*WIDTH_OUT-1:0] q,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic [CNT_W-1:0]              xfer_count
);

  localparam int DATA_W = CHANNELS * WIDTH_OUT;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  // IGNORED only exists so that older parameter overrides still elaborate.
  if (IGNORED < 0) begin : g_ignored_param
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [DATA_W-1:0] in_data_p0;
  logic [DEPTH:0]    v_chain;
  logic [DEPTH:0]    rdy_chain;
  logic [DATA_W-1:0] d_chain [DEPTH+1];
  logic [OCC_W-1:0]  occ_cnt;
  logic              out_xfer;

  // ---- input: per-lane width/sign adaptation ahead of stage 0 ----
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    assign in_data_p0[k*WIDTH_OUT +: WIDTH_OUT] =
      WIDTH_OUT'(ext_lane(EXT_W'(a[k*WIDTH_IN +: WIDTH_IN]), WIDTH_IN, signed_mode));
  end

  assign v_chain[0]       = in_valid;
  assign d_chain[0]       = in_data_p0;
  assign rdy_chain[DEPTH] = q_ready;
  assign in_ready         = rdy_chain[0];

  // ---- stages 0..DEPTH-1: slice i reads chain entry i and drives entry i+1 ----
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    v_hier_subsub_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .up_valid(v_chain[i]),
      .up_data (d_chain[i]),
      .dn_ready(rdy_chain[i+1]),
      .valid   (v_chain[i+1]),
      .data    (d_chain[i+1]),
      .rdy     (rdy_chain[i])
    );
  end

  // ---- output: registered last stage, occupancy and transfer count ----
  assign q_valid  = v_chain[DEPTH];
  assign q        = d_chain[DEPTH];
  assign out_xfer = q_valid & q_ready;

  always_comb begin
    occ_cnt = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      occ_cnt = occ_cnt + OCC_W'(v_chain[i]);
    end
  end

  assign occupancy = occ_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (out_xfer) begin
      xfer_count <= sat_inc(xfer_count);
    end
  end

endmodule

// File: tb/tb_v_hier_subsub_pipe.sv
// Directed bench for v_hier_subsub_pipe: extension, truncation, back-pressure,
// throughput, counter saturation and asynchronous reset mid-stream.
module tb_v_hier_subsub_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        signed_mode;
  logic        q_ready;
  logic [1:0]  a;
  logic [23:0] a_t;

  logic        in_ready, q_valid;
  logic [15:0] q;
  logic [1:0]  occupancy;
  logic [15:0] xfer_count;

  logic        s_in_ready, s_q_valid;
  logic [15:0] s_q;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_xfer_count;

  logic        t_in_ready, t_q_valid;
  logic [15:0] t_q;
  logic [1:0]  t_occupancy;
  logic [15:0] t_xfer_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  v_hier_subsub_pipe #(.WIDTH_IN(1), .WIDTH_OUT(8), .CHANNELS(2), .DEPTH(2), .CNT_W(16)) u_main (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .signed_mode(signed_mode), .q_valid(q_valid), .q_ready(q_ready), .q(q),
    .occupancy(occupancy), .xfer_count(xfer_count));

  v_hier_subsub_pipe #(.WIDTH_IN(1), .WIDTH_OUT(8), .CHANNELS(2), .DEPTH(2), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .a(a),
    .signed_mode(signed_mode), .q_valid(s_q_valid), .q_ready(q_ready), .q(s_q),
    .occupancy(s_occupancy), .xfer_count(s_xfer_count));

  v_hier_subsub_pipe #(.WIDTH_IN(12), .WIDTH_OUT(8), .CHANNELS(2), .DEPTH(2), .CNT_W(16)) u_trunc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(t_in_ready), .a(a_t),
    .signed_mode(signed_mode), .q_valid(t_q_valid), .q_ready(q_ready), .q(t_q),
    .occupancy(t_occupancy), .xfer_count(t_xfer_count));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed extension vectors: {a, signed_mode, expected q}
  logic [1:0]  ext_a   [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
  logic        ext_sm  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] ext_exp [4] = '{16'h00FF, 16'h0001, 16'hFF00, 16'h0101};
  logic [15:0] bp_exp  [3] = '{16'h0001, 16'h0100, 16'h0101};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, nin, nout, first_out, errs, stalls;
    logic hs_in, hs_out;
    logic [1:0]  pat;
    logic [15:0] exp_q;

    reset = 1'b1; in_valid = 1'b0; signed_mode = 1'b0; q_ready = 1'b1;
    a = 2'b00; a_t = {12'h3C7, 12'hA5C};
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_q_valid", q_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_xfer", xfer_count, 0);
    reset = 1'b0;
    tick();

    // Sign/zero extension and truncation, one beat at a time
    for (int v = 0; v < 4; v++) begin
      a = ext_a[v]; signed_mode = ext_sm[v]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("ext_q_valid", q_valid, 1);
      check("ext_q", q, ext_exp[v]);
      check("trunc_q", t_q, 16'hC75C);
      tick();
    end
    check("ext_q_valid_drained", q_valid, 0);
    check("ext_xfer", xfer_count, 4);
    check("ext_occ", occupancy, 0);

    // Back-pressure: three beats against a stalled sink
    signed_mode = 1'b0; q_ready = 1'b0;
    a = 2'b01; in_valid = 1'b1;
    tick();
    a = 2'b10; #1;
    check("bp_ready_1", in_ready, 1);
    tick();
    a = 2'b11; #1;
    check("bp_ready_full", in_ready, 0);
    check("bp_occ_full", occupancy, 2);
    check("bp_q_head", q, 16'h0001);
    tick(); tick();
    check("bp_q_stable", q, 16'h0001);
    check("bp_ready_held", in_ready, 0);
    check("bp_xfer_held", xfer_count, 4);

    q_ready = 1'b1; #1;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      hs_in  = in_valid && in_ready;
      hs_out = q_valid && q_ready;
      if (hs_out) begin
        if (idx < 3) check("bp_order", q, bp_exp[idx]);
        idx++;
      end
      tick();
      if (hs_in) in_valid = 1'b0;
      #1;
    end
    check("bp_count", idx, 3);
    check("bp_xfer", xfer_count, 7);

    // Throughput: 100 beats with the sink always ready
    nin = 0; nout = 0; first_out = -1; errs = 0; stalls = 0;
    for (int c = 0; c < 110; c++) begin
      if (nin < 100) begin
        pat = nin[1:0]; a = pat; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) stalls++;
      if (c == 50 || c == 51) check("tp_occ_full", occupancy, 2);
      if (q_valid && q_ready) begin
        if (first_out < 0) first_out = c;
        pat   = nout[1:0];
        exp_q = {7'b0, pat[1], 7'b0, pat[0]};
        if (q !== exp_q) errs++;
        nout++;
      end
      if (in_valid && in_ready) nin++;
      tick();
    end
    check("tp_first_cycle", first_out, 2);
    check("tp_beats", nout, 100);
    check("tp_data_errs", errs, 0);
    check("tp_stalls", stalls, 0);
    check("tp_xfer", xfer_count, 107);
    check("sat_xfer", s_xfer_count, 15);

    // Asynchronous reset with two beats in flight
    q_ready = 1'b0; signed_mode = 1'b1; a = 2'b01; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0; #1;
    check("mid_occ_before", occupancy, 2);
    reset = 1'b1; #1;
    check("mid_q_valid", q_valid, 0);
    check("mid_occ", occupancy, 0);
    check("mid_xfer", xfer_count, 0);
    check("mid_sat_xfer", s_xfer_count, 0);
    check("mid_in_ready", in_ready, 1);
    tick();
    reset = 1'b0; q_ready = 1'b1;
    tick(); tick();
    check("mid_no_partial", q_valid, 0);
    check("mid_xfer_after", xfer_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
